// File: rtl/pong_pkg.sv
// Shared definitions for the pong display path: matrix geometry, the blank
// levels of the LED matrix pins and the scanner state encoding.
package pong_pkg;

  localparam int MATRIX_W = 8;

  // Column mask is active high, row select is active low, so "nothing lit"
  // is all columns off and all rows deselected.
  localparam logic [MATRIX_W-1:0] COL_OFF = 8'h00;
  localparam logic [MATRIX_W-1:0] ROW_OFF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHOW,
    BLANK
  } scan_state_t;

  // Used when sizing the shared dwell/blank counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Bundle between the draw sources and the matrix scanner.
//
// There is no valid/ready handshake on this bundle: en is a level enable and
// the source masks are plain levels. A source is sampled only on the single
// edge where the scanner loads its slot; every other edge ignores the sources.
// The matrix outputs are registered levels, frame_tick is a one-cycle pulse.
interface led_matrix_scanner_if #(
  parameter int NUM_SRC = 3
);
  import pong_pkg::*;

  logic                         en;
  logic [MATRIX_W*NUM_SRC-1:0]  src_sx;
  logic [MATRIX_W*NUM_SRC-1:0]  src_sy;
  logic [MATRIX_W-1:0]          mat_sx;
  logic [MATRIX_W-1:0]          mat_sy;
  logic                         frame_tick;
  scan_state_t                  dbg_state;

  // Draw side: drives enable and sources, observes the matrix.
  modport master (
    output en,
    output src_sx,
    output src_sy,
    input  mat_sx,
    input  mat_sy,
    input  frame_tick,
    input  dbg_state
  );

  // Scanner side.
  modport slave (
    input  en,
    input  src_sx,
    input  src_sy,
    output mat_sx,
    output mat_sy,
    output frame_tick,
    output dbg_state
  );

endinterface

// File: rtl/led_matrix_scanner.sv
// Time-multiplexes NUM_SRC (Sx, Sy) draw sources onto one 8x8 LED matrix.
// Each active source is snapshotted and held for DWELL_CYCLES clocks, then the
// matrix is forced blank for BLANK_CYCLES clocks so no row ghosts into the
// next source. Inactive sources are skipped at a cost of one clock each.
module led_matrix_scanner
  import pong_pkg::*;
#(
  parameter int NUM_SRC      = 3,
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  led_matrix_scanner_if.slave  bus
);

  localparam int SLOT_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int SLOT_N = 1 << SLOT_W;
  localparam int CNT_W  = $clog2(max_int(DWELL_CYCLES, BLANK_CYCLES) + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SRC - 1);
  localparam logic [CNT_W-1:0]  DWELL_LD  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BLANK_LD  = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

  scan_state_t          state_q, state_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MATRIX_W-1:0]  mat_sx_q, mat_sx_d;
  logic [MATRIX_W-1:0]  mat_sy_q, mat_sy_d;
  logic                 frame_tick_q, frame_tick_d;

  // Source mux. Slot codes beyond NUM_SRC-1 are unreachable; they are padded
  // with the blank pattern so the mux is total over the slot width.
  logic [MATRIX_W-1:0]  sx_arr [SLOT_N];
  logic [MATRIX_W-1:0]  sy_arr [SLOT_N];
  logic [MATRIX_W-1:0]  cur_sx;
  logic [MATRIX_W-1:0]  cur_sy;
  logic                 cur_active;
  logic                 advance;

  for (genvar g = 0; g < SLOT_N; g++) begin : g_mux
    if (g < NUM_SRC) begin : g_src
      assign sx_arr[g] = bus.src_sx[MATRIX_W*g +: MATRIX_W];
      assign sy_arr[g] = bus.src_sy[MATRIX_W*g +: MATRIX_W];
    end else begin : g_pad
      assign sx_arr[g] = COL_OFF;
      assign sy_arr[g] = ROW_OFF;
    end
  end

  assign cur_sx     = sx_arr[slot_q];
  assign cur_sy     = sy_arr[slot_q];
  assign cur_active = (cur_sx != COL_OFF) && (cur_sy != ROW_OFF);

  // State, slot, counter and the registered matrix pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      cnt_q        <= '0;
      mat_sx_q     <= COL_OFF;
      mat_sy_q     <= ROW_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      cnt_q        <= cnt_d;
      mat_sx_q     <= mat_sx_d;
      mat_sy_q     <= mat_sy_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Next state and next outputs; blank is the default so that only the
  // LOAD snapshot and SHOW hold can ever put a source on the pins.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    cnt_d        = cnt_q;
    mat_sx_d     = COL_OFF;
    mat_sy_d     = ROW_OFF;
    frame_tick_d = 1'b0;
    advance      = 1'b0;

    if (!bus.en) begin
      // Disable wins over everything and restarts the frame at slot 0.
      state_d = IDLE;
      slot_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = LOAD;
        end
        LOAD: begin
          if (cur_active) begin
            mat_sx_d = cur_sx;
            mat_sy_d = cur_sy;
            cnt_d    = DWELL_LD;
            state_d  = SHOW;
          end else begin
            advance = 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == '0) begin
            if (BLANK_CYCLES > 0) begin
              cnt_d   = BLANK_LD;
              state_d = BLANK;
            end else begin
              advance = 1'b1;
              state_d = LOAD;
            end
          end else begin
            // Hold the snapshot; live source changes are ignored here.
            cnt_d    = cnt_q - 1'b1;
            mat_sx_d = mat_sx_q;
            mat_sy_d = mat_sy_q;
          end
        end
        BLANK: begin
          if (cnt_q == '0) begin
            advance = 1'b1;
            state_d = LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (advance) begin
        frame_tick_d = (slot_q == SLOT_LAST);
        slot_d       = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
      end
    end
  end

  assign bus.mat_sx     = mat_sx_q;
  assign bus.mat_sy     = mat_sy_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner. Two instances share one set of sources and
// enable: one with BLANK_CYCLES=1 and one with BLANK_CYCLES=0. Each has a
// schedule model that, when a slot is taken, queues the whole future output
// sequence of that slot; a compare process checks every cycle.
module tb_led_matrix_scanner;
  import pong_pkg::*;

  localparam int N  = 3;
  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [7:0]  sx [N];
  logic [7:0]  sy [N];
  logic [23:0] src_sx_all;
  logic [23:0] src_sy_all;
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;

  assign src_sx_all = {sx[2], sx[1], sx[0]};
  assign src_sy_all = {sy[2], sy[1], sy[0]};

  // Clock and cycle count.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int BC = (k == 0) ? 1 : 0;

    led_matrix_scanner_if #(.NUM_SRC(N)) bus ();
    assign bus.en     = en;
    assign bus.src_sx = src_sx_all;
    assign bus.src_sy = src_sy_all;

    led_matrix_scanner #(
      .NUM_SRC      (N),
      .DWELL_CYCLES (DW),
      .BLANK_CYCLES (BC)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    // Schedule model: entries are {tick, sx, sy} for the edges to come.
    logic [7:0]  exp_sx   = 8'h00;
    logic [7:0]  exp_sy   = 8'hFF;
    logic        exp_tick = 1'b0;
    bit          m_idle   = 1'b1;
    int          m_slot   = 0;
    logic [16:0] m_q [$];
    logic [16:0] m_o;
    int          last_tick = -1;
    int          period    = 0;

    task automatic model_reset(output logic [16:0] o);
      m_idle = 1'b1;
      m_slot = 0;
      m_q.delete();
      o = {1'b0, 8'h00, 8'hFF};
    endtask

    task automatic model_step(output logic [16:0] o);
      logic [7:0] s_x;
      logic [7:0] s_y;
      logic       wrap;
      if (!en) begin
        model_reset(o);
      end else if (m_idle) begin
        m_idle = 1'b0;
        o = {1'b0, 8'h00, 8'hFF};
      end else if (m_q.size() != 0) begin
        o = m_q.pop_front();
      end else begin
        s_x  = src_sx_all[8*m_slot +: 8];
        s_y  = src_sy_all[8*m_slot +: 8];
        wrap = (m_slot == N - 1);
        if (s_x != 8'h00 && s_y != 8'hFF) begin
          o = {1'b0, s_x, s_y};
          for (int i = 1; i < DW; i++) m_q.push_back({1'b0, s_x, s_y});
          for (int i = 0; i < BC; i++) m_q.push_back({1'b0, 8'h00, 8'hFF});
          m_q.push_back({wrap, 8'h00, 8'hFF});
        end else begin
          o = {wrap, 8'h00, 8'hFF};
        end
        m_slot = (m_slot + 1) % N;
      end
    endtask

    // Advance the model on each edge; reset acts immediately.
    always @(posedge clk or posedge rst) begin
      if (rst) model_reset(m_o);
      else     model_step(m_o);
      {exp_tick, exp_sx, exp_sy} <= m_o;
    end

    // Interval between successive frame ticks, as seen on the DUT pins.
    always @(negedge clk) begin
      if (rst || !en) begin
        last_tick <= -1;
      end else if (bus.frame_tick) begin
        if (last_tick >= 0) period <= cyc - last_tick;
        last_tick <= cyc;
      end
    end
  end

  // Cycle-by-cycle comparison against the models.
  always @(negedge clk) begin
    chk("a_sx",   32'(g_dut[0].bus.mat_sx),     32'(g_dut[0].exp_sx));
    chk("a_sy",   32'(g_dut[0].bus.mat_sy),     32'(g_dut[0].exp_sy));
    chk("a_tick", 32'(g_dut[0].bus.frame_tick), 32'(g_dut[0].exp_tick));
    chk("b_sx",   32'(g_dut[1].bus.mat_sx),     32'(g_dut[1].exp_sx));
    chk("b_sy",   32'(g_dut[1].bus.mat_sy),     32'(g_dut[1].exp_sy));
    chk("b_tick", 32'(g_dut[1].bus.frame_tick), 32'(g_dut[1].exp_tick));
  end

  // Wait (bounded) until instance A shows column mask v; a timeout fails.
  task automatic wait_a_sx(input logic [7:0] v, input int budget, input string name);
    int n = 0;
    while (g_dut[0].bus.mat_sx !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(g_dut[0].bus.mat_sx), 32'(v));
  endtask

  task automatic chk_blank_idle(input string name);
    chk({name, "_a_sx"},  32'(g_dut[0].bus.mat_sx),     32'h00);
    chk({name, "_a_sy"},  32'(g_dut[0].bus.mat_sy),     32'hFF);
    chk({name, "_a_tk"},  32'(g_dut[0].bus.frame_tick), 32'h0);
    chk({name, "_a_st"},  32'(g_dut[0].bus.dbg_state),  32'(IDLE));
    chk({name, "_b_sx"},  32'(g_dut[1].bus.mat_sx),     32'h00);
    chk({name, "_b_st"},  32'(g_dut[1].bus.dbg_state),  32'(IDLE));
  endtask

  initial begin
    sx = '{8'h1C, 8'h07, 8'h08};
    sy = '{8'h7F, 8'hFE, 8'hEF};
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    chk_blank_idle("reset");

    // Normal frame: first source visible two edges after enable.
    rst = 1'b0;
    en  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("first_a_sx", 32'(g_dut[0].bus.mat_sx), 32'h1C);
    chk("first_a_sy", 32'(g_dut[0].bus.mat_sy), 32'h7F);
    chk("first_b_sx", 32'(g_dut[1].bus.mat_sx), 32'h1C);
    repeat (45) @(negedge clk);
    chk("frame_a", 32'(g_dut[0].period), 32'd18);
    chk("frame_b", 32'(g_dut[1].period), 32'd15);

    // Skip of an inactive source.
    sx[1] = 8'h00;
    repeat (45) @(negedge clk);
    chk("skip_a", 32'(g_dut[0].period), 32'd13);
    chk("skip_b", 32'(g_dut[1].period), 32'd11);

    // Nothing active: one slot per cycle.
    sx = '{8'h00, 8'h00, 8'h00};
    repeat (12) @(negedge clk);
    chk("none_a", 32'(g_dut[0].period), 32'd3);
    chk("none_b", 32'(g_dut[1].period), 32'd3);

    // Snapshot: a change mid-dwell is not shown until the next frame.
    en = 1'b0;
    sx = '{8'h1C, 8'h07, 8'h08};
    repeat (2) @(negedge clk);
    en = 1'b1;
    wait_a_sx(8'h1C, 10, "snap_start");
    @(posedge clk);
    #1 sx[0] = 8'hE0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("snap_hold", 32'(g_dut[0].bus.mat_sx), 32'h1C);
    end
    wait_a_sx(8'hE0, 30, "snap_next");

    // Enable dropped while source 1 is on the matrix.
    wait_a_sx(8'h07, 30, "drop_src1");
    en = 1'b0;
    @(negedge clk);
    chk_blank_idle("drop");
    en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reen_a_sx", 32'(g_dut[0].bus.mat_sx), 32'hE0);
    chk("reen_a_sy", 32'(g_dut[0].bus.mat_sy), 32'h7F);
    chk("reen_b_sx", 32'(g_dut[1].bus.mat_sx), 32'hE0);

    // Asynchronous reset while showing: pins blank before the next edge.
    #2 rst = 1'b1;
    #1;
    chk("arst_a_sx", 32'(g_dut[0].bus.mat_sx),     32'h00);
    chk("arst_a_sy", 32'(g_dut[0].bus.mat_sy),     32'hFF);
    chk("arst_a_tk", 32'(g_dut[0].bus.frame_tick), 32'h0);
    chk("arst_b_sx", 32'(g_dut[1].bus.mat_sx),     32'h00);
    @(negedge clk);
    rst = 1'b0;

    // Randomized sources, enable drops and occasional resets.
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        int idx;
        idx = int'($urandom_range(0, N - 1));
        sx[idx] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        sy[idx] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      end
      en  = ($urandom_range(0, 49) != 0);
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    en  = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
